vga_sync_fifo_prog: RTL and testbench

Single-clock synchronous FIFO for the VGA/SDRAM datapath, successor to the fixed-depth VGA line FIFO. It adds a full-width occupancy count, runtime-programmable almost-full/almost-empty thresholds, and a selectable read mode (show-ahead or registered). It also adds write/read protection with sticky overflow/underflow flags. It sits between the SDRAM read burst engine and the pixel output stage, and is reusable for any same-clock buffering in the device tree.

---
 rtl/vga_sync_fifo_pkg.sv | 9 +
 rtl/vga_sync_fifo_ram.sv | 21 ++
 rtl/vga_sync_fifo_prog.sv | 93 +++++++++
 tb/tb_vga_sync_fifo_prog.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/vga_sync_fifo_pkg.sv
// vga_sync_fifo_pkg: shared read-mode encodings and geometry check for the programmable VGA FIFO.
package vga_sync_fifo_pkg;
    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic bit depth_ok(input int depth, input int d_n);
        return (d_n >= 1) && (depth == (1 << d_n));
    endfunction
endpackage

// File: rtl/vga_sync_fifo_ram.sv
// vga_sync_fifo_ram: N x DEPTH storage, synchronous write, asynchronous read.
module vga_sync_fifo_ram #(
    parameter int N     = 16,
    parameter int DEPTH = 16,
    parameter int D_N   = 4
) (
    input  logic           clk,
    input  logic           we,
    input  logic [D_N-1:0] waddr,
    input  logic [N-1:0]   wdata,
    input  logic [D_N-1:0] raddr,
    output logic [N-1:0]   rdata
);
    logic [N-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/vga_sync_fifo_prog.sv
// vga_sync_fifo_prog: single-clock FIFO with occupancy count, programmable thresholds,
// selectable show-ahead/registered read and sticky overflow/underflow flags.
module vga_sync_fifo_prog
    import vga_sync_fifo_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 16,
    parameter int D_N   = 4,
    parameter int FWFT  = 1
) (
    input  logic         iCLOCK,
    input  logic         inRESET,
    input  logic         iREMOVE,
    input  logic         iERR_CLEAR,
    input  logic [D_N:0] iAF_LEVEL,
    input  logic [D_N:0] iAE_LEVEL,
    output logic [D_N:0] oCOUNT,
    input  logic         iWR_EN,
    input  logic [N-1:0] iWR_DATA,
    output logic         oWR_FULL,
    output logic         oWR_ALMOST_FULL,
    input  logic         iRD_EN,
    output logic [N-1:0] oRD_DATA,
    output logic         oRD_VALID,
    output logic         oRD_EMPTY,
    output logic         oRD_ALMOST_EMPTY,
    output logic         oOVERFLOW,
    output logic         oUNDERFLOW
);
    localparam logic [D_N:0] DEPTH_W = (D_N+1)'(DEPTH);

    if (!depth_ok(DEPTH, D_N)) begin : g_bad_depth
        $error("vga_sync_fifo_prog: DEPTH must equal 2**D_N");
    end

    logic [D_N:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic         ovf_q, ovf_d, udf_q, udf_d, vld_q, vld_d;
    logic [N-1:0] dout_q, dout_d, ram_rdata;
    logic         full, empty, wr_acc, rd_acc;

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = count == DEPTH_W;
    assign empty = count == '0;

    always_comb begin
        wr_acc   = iWR_EN & ~full;
        rd_acc   = iRD_EN & ~empty;
        wr_ptr_d = iREMOVE ? '0 : wr_ptr_q + {{D_N{1'b0}}, wr_acc};
        rd_ptr_d = iREMOVE ? '0 : rd_ptr_q + {{D_N{1'b0}}, rd_acc};
        ovf_d    = ~iREMOVE & ((iWR_EN & full) | (ovf_q & ~iERR_CLEAR));
        udf_d    = ~iREMOVE & ((iRD_EN & empty) | (udf_q & ~iERR_CLEAR));
        vld_d    = ~iREMOVE & rd_acc;
        dout_d   = vld_d ? ram_rdata : dout_q;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            vld_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            vld_q    <= vld_d;
            dout_q   <= dout_d;
        end
    end

    vga_sync_fifo_ram #(.N(N), .DEPTH(DEPTH), .D_N(D_N)) u_ram (
        .clk  (iCLOCK),
        .we   (wr_acc & ~iREMOVE),
        .waddr(wr_ptr_q[D_N-1:0]),
        .wdata(iWR_DATA),
        .raddr(rd_ptr_q[D_N-1:0]),
        .rdata(ram_rdata)
    );

    // Thresholds beyond the reachable count range saturate naturally.
    assign oCOUNT           = count;
    assign oWR_FULL         = full;
    assign oRD_EMPTY        = empty;
    assign oWR_ALMOST_FULL  = count >= iAF_LEVEL;
    assign oRD_ALMOST_EMPTY = count <= iAE_LEVEL;
    assign oOVERFLOW        = ovf_q;
    assign oUNDERFLOW       = udf_q;
    assign oRD_DATA         = (FWFT == FIFO_MODE_FWFT) ? ram_rdata : dout_q;
    assign oRD_VALID        = (FWFT == FIFO_MODE_FWFT) ? ~empty : vld_q;
endmodule

// File: tb/tb_vga_sync_fifo_prog.sv
// tb_vga_sync_fifo_prog: directed checks of a DEPTH=4 FIFO in show-ahead and registered modes.
module tb_vga_sync_fifo_prog;
    logic        clk = 1'b0, rst_n = 1'b0, remove = 1'b0, err_clr = 1'b0;
    logic [2:0]  af_lvl = 3'd3, ae_lvl = 3'd1;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic [2:0]  a_cnt, b_cnt;
    logic        a_full, a_af, a_vld, a_emp, a_ae, a_ovf, a_udf;
    logic        b_full, b_af, b_vld, b_emp, b_ae, b_ovf, b_udf;
    logic [15:0] a_dat, b_dat;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    vga_sync_fifo_prog #(.N(16), .DEPTH(4), .D_N(2), .FWFT(1)) u_a (
        .iCLOCK(clk), .inRESET(rst_n), .iREMOVE(remove), .iERR_CLEAR(err_clr),
        .iAF_LEVEL(af_lvl), .iAE_LEVEL(ae_lvl), .oCOUNT(a_cnt),
        .iWR_EN(wr_en), .iWR_DATA(wr_data), .oWR_FULL(a_full), .oWR_ALMOST_FULL(a_af),
        .iRD_EN(rd_en), .oRD_DATA(a_dat), .oRD_VALID(a_vld), .oRD_EMPTY(a_emp),
        .oRD_ALMOST_EMPTY(a_ae), .oOVERFLOW(a_ovf), .oUNDERFLOW(a_udf)
    );

    vga_sync_fifo_prog #(.N(16), .DEPTH(4), .D_N(2), .FWFT(0)) u_b (
        .iCLOCK(clk), .inRESET(rst_n), .iREMOVE(remove), .iERR_CLEAR(err_clr),
        .iAF_LEVEL(af_lvl), .iAE_LEVEL(ae_lvl), .oCOUNT(b_cnt),
        .iWR_EN(wr_en), .iWR_DATA(wr_data), .oWR_FULL(b_full), .oWR_ALMOST_FULL(b_af),
        .iRD_EN(rd_en), .oRD_DATA(b_dat), .oRD_VALID(b_vld), .oRD_EMPTY(b_emp),
        .oRD_ALMOST_EMPTY(b_ae), .oOVERFLOW(b_ovf), .oUNDERFLOW(b_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic w, input logic r, input logic [15:0] d);
        wr_en = w;
        rd_en = r;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_cnt", a_cnt, 0);
        chk("rst_emp", a_emp, 1);
        chk("rst_full", a_full, 0);
        chk("rst_ae", a_ae, 1);
        chk("rst_af", a_af, 0);
        chk("rst_flags", {a_ovf, a_udf, a_vld, b_vld}, 0);
        chk("rst_bdat", b_dat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        op(1, 0, 16'hA0);
        chk("w1_cnt", a_cnt, 1);
        chk("w1_emp_vld", {a_emp, a_vld}, 2'b01);
        chk("w1_dat", a_dat, 16'hA0);
        chk("w1_ae_af", {a_ae, a_af}, 2'b10);
        op(1, 0, 16'hA1);
        chk("w2_ae_af", {a_ae, a_af}, 2'b00);
        af_lvl = 3'd2;
        #1;
        chk("af_lvl2", a_af, 1);
        af_lvl = 3'd3;
        #1;
        chk("af_lvl3", a_af, 0);
        op(1, 0, 16'hA2);
        chk("w3_af", a_af, 1);
        op(1, 0, 16'hA3);
        chk("w4_cnt_full", {a_cnt, a_full, a_af}, {3'd4, 2'b11});
        op(1, 0, 16'hFF);
        chk("ovf_cnt", a_cnt, 4);
        chk("ovf_set", a_ovf, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("ovf_clr", a_ovf, 0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_dat", a_dat, 16'hA0 + 16'(i));
            op(0, 1, 0);
            if (i == 0) chk("b_first", {b_vld, b_dat}, {1'b1, 16'hA0});
        end
        chk("drain_emp", {a_cnt, a_emp, a_vld, a_ae}, {3'd0, 3'b101});
        chk("drain_udf", a_udf, 0);
        for (int i = 0; i < 4; i++) op(1, 0, 16'hB0 + 16'(i));
        op(1, 1, 16'hCC);
        chk("full_rw_cnt", a_cnt, 3);
        chk("full_rw_ovf", a_ovf, 1);
        chk("full_rw_dat", a_dat, 16'hB1);
        for (int i = 0; i < 3; i++) op(0, 1, 0);
        chk("refill_emp", a_emp, 1);
        op(1, 1, 16'hDD);
        chk("emp_rw_cnt", a_cnt, 1);
        chk("emp_rw_udf", a_udf, 1);
        chk("emp_rw_dat", a_dat, 16'hDD);
        op(1, 0, 16'h01);
        op(1, 0, 16'h02);
        chk("pre_flush", {a_cnt, a_ovf}, {3'd3, 1'b1});
        remove = 1'b1;
        op(1, 0, 16'hEE);
        remove = 1'b0;
        chk("flush_cnt", a_cnt, 0);
        chk("flush_st", {a_emp, a_ovf, a_udf, a_vld, b_vld}, 5'b10000);
        op(1, 0, 16'h11);
        op(1, 0, 16'h22);
        chk("b_pre_vld", b_vld, 0);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        chk("b_rd1", {b_vld, b_dat}, {1'b1, 16'h11});
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        chk("b_rd2", {b_vld, b_dat}, {1'b1, 16'h22});
        @(posedge clk);
        #1;
        chk("b_idle", {b_vld, b_dat, b_emp}, {1'b0, 16'h22, 1'b1});
        wr_en = 1'b1;
        wr_data = 16'h33;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", a_cnt, 0);
        chk("arst_st", {a_emp, a_full, a_ae, a_ovf, a_udf, b_vld}, 6'b101000);
        chk("arst_bdat", b_dat, 0);
        wr_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
